// File: rtl/surf_rackctl_mphy_if.sv
// Transaction bus between the rackctl bridge (master) and the RACKctl PHY engine (slave).
interface surf_rackctl_mphy_if #(
    parameter int ADDR_BITS = 24,
    parameter int DATA_BITS = 32
);
    logic                 mode_i;
    logic [ADDR_BITS-1:0] txn_addr_i;
    logic [DATA_BITS-1:0] txn_data_i;
    logic                 txn_start_i;
    logic [DATA_BITS-1:0] txn_resp_o;
    logic                 txn_done_o;
    logic                 txn_err_o;
    logic                 txn_perr_o;
    logic                 mode_o;

    // Handshake: txn_start_i is a 1-clk strobe with addr/data/mode valid alongside it; the master
    // holds addr/data until txn_done_o or txn_err_o pulses. There is no ready: a strobe while busy is dropped.
    modport master (
        output mode_i, txn_addr_i, txn_data_i, txn_start_i,
        input  txn_resp_o, txn_done_o, txn_err_o, txn_perr_o, mode_o
    );
    modport slave (
        input  mode_i, txn_addr_i, txn_data_i, txn_start_i,
        output txn_resp_o, txn_done_o, txn_err_o, txn_perr_o, mode_o
    );
endinterface

// File: rtl/surf_rackctl_mphy.sv
// RACKctl PHY engine, TURFIO side: serialises bridge transactions on the half-duplex line,
// captures the SURF response, checks parity and re-issues on timeout/parity failure.
module surf_rackctl_mphy #(
    parameter int ADDR_BITS       = 24,
    parameter int DATA_BITS       = 32,
    parameter int TURNAROUND_CLKS = 128,
    parameter int TIMEOUT_CLKS    = 128,
    parameter int MAX_RETRY       = 1
) (
    input  logic                sysclk_i,
    input  logic                rst_i,
    surf_rackctl_mphy_if.slave  bus,
    output logic                rack_out_o,
    output logic                rack_tri_o,
    output logic                rack_ce_o,
    input  logic                rack_in_i,
    output logic [3:0]          state_o
);
    localparam int TXW     = ADDR_BITS + DATA_BITS;
    localparam int M1      = (TURNAROUND_CLKS > TIMEOUT_CLKS) ? TURNAROUND_CLKS : TIMEOUT_CLKS;
    localparam int M2      = (ADDR_BITS > DATA_BITS + 1) ? ADDR_BITS : DATA_BITS + 1;
    localparam int M3      = (M1 > M2) ? M1 : M2;
    localparam int CNT_MAX = (M3 > 5) ? M3 : 5;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int RW      = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    typedef enum logic [3:0] {
        S_IDLE0, S_IDLE1, S_PRE, S_ADDR, S_DATA, S_PAR, S_TA0,
        S_POST, S_START, S_CAP, S_DONE, S_FAIL, S_TA1
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [RW-1:0]        retry_q, retry_d;
    logic [TXW-1:0]       tx_q, tx_d;
    logic [DATA_BITS-1:0] rx_q, rx_d, resp_q, resp_d;
    logic                 mode_q, mode_d, par_q, par_d, is_read_q, is_read_d;
    logic                 switch_q, switch_d, pend_q, pend_d, rerun_q, rerun_d, perr_q, perr_d;
    logic                 can_retry;

    assign can_retry = (retry_q < RW'(MAX_RETRY));

    always_ff @(posedge sysclk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE0;
            cnt_q     <= '0;
            retry_q   <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
            resp_q    <= '0;
            mode_q    <= 1'b0;
            par_q     <= 1'b0;
            is_read_q <= 1'b0;
            switch_q  <= 1'b0;
            pend_q    <= 1'b0;
            rerun_q   <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            resp_q    <= resp_d;
            mode_q    <= mode_d;
            par_q     <= par_d;
            is_read_q <= is_read_d;
            switch_q  <= switch_d;
            pend_q    <= pend_d;
            rerun_q   <= rerun_d;
            perr_q    <= perr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        retry_d   = retry_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        resp_d    = resp_q;
        mode_d    = mode_q;
        par_d     = par_q;
        is_read_d = is_read_q;
        switch_d  = switch_q;
        pend_d    = pend_q;
        rerun_d   = rerun_q;
        perr_d    = perr_q;
        case (state_q)
            S_IDLE0, S_IDLE1: begin
                // A mode change outranks a start; the start is parked and issued once the new mode is idle.
                if (bus.mode_i != mode_q) begin
                    pend_d = pend_q | bus.txn_start_i;
                    if (mode_q) begin
                        mode_d  = 1'b0;
                        state_d = S_DONE;
                    end else begin
                        switch_d = 1'b1;
                        state_d  = S_TA0;
                    end
                end else if (bus.txn_start_i || pend_q) begin
                    pend_d    = 1'b0;
                    retry_d   = '0;
                    is_read_d = mode_q | bus.txn_addr_i[ADDR_BITS-1];
                    tx_d      = {bus.txn_addr_i, bus.txn_data_i};
                    par_d     = 1'b0;
                    state_d   = mode_q ? S_POST : S_PRE;
                end
            end
            S_PRE: if (cnt_q == CW'(4)) state_d = S_ADDR;
            S_ADDR: begin
                tx_d  = tx_q << 1;
                par_d = par_q ^ tx_q[TXW-1];
                if (cnt_q == CW'(ADDR_BITS - 1)) state_d = is_read_q ? S_PAR : S_DATA;
            end
            S_DATA: begin
                tx_d  = tx_q << 1;
                par_d = par_q ^ tx_q[TXW-1];
                if (cnt_q == CW'(DATA_BITS - 1)) state_d = S_PAR;
            end
            S_PAR: state_d = S_TA0;
            S_TA0: begin
                if (cnt_q == CW'(TURNAROUND_CLKS - 1)) begin
                    if (switch_q) begin
                        switch_d = 1'b0;
                        mode_d   = 1'b1;
                        state_d  = S_DONE;
                    end else begin
                        state_d = S_POST;
                    end
                end
            end
            S_POST: begin
                if (rack_in_i) begin
                    state_d = S_START;
                end else begin
                    perr_d  = 1'b0;
                    state_d = S_FAIL;
                end
            end
            S_START: begin
                if (!rack_in_i) begin
                    state_d = is_read_q ? S_CAP : S_DONE;
                end else if (cnt_q == CW'(TIMEOUT_CLKS - 1)) begin
                    perr_d  = 1'b0;
                    state_d = S_FAIL;
                end
            end
            S_CAP: begin
                // Last CAP clock carries the parity bit: 1 when the data word holds an even number of ones.
                if (cnt_q == CW'(DATA_BITS)) begin
                    if (rack_in_i == ~^rx_q) begin
                        resp_d  = rx_q;
                        state_d = S_DONE;
                    end else begin
                        perr_d  = 1'b1;
                        state_d = S_FAIL;
                    end
                end else begin
                    rx_d = {rx_q[DATA_BITS-2:0], rack_in_i};
                end
            end
            S_DONE: state_d = mode_q ? S_IDLE1 : S_TA1;
            S_FAIL: begin
                if (can_retry) begin
                    retry_d = retry_q + RW'(1);
                    if (mode_q) begin
                        state_d = S_POST;
                    end else begin
                        rerun_d = 1'b1;
                        state_d = S_TA1;
                    end
                end else begin
                    state_d = mode_q ? S_IDLE1 : S_TA1;
                end
            end
            S_TA1: begin
                if (cnt_q == CW'(TURNAROUND_CLKS - 1)) begin
                    if (rerun_q) begin
                        rerun_d = 1'b0;
                        tx_d    = {bus.txn_addr_i, bus.txn_data_i};
                        par_d   = 1'b0;
                        state_d = S_PRE;
                    end else begin
                        state_d = S_IDLE0;
                    end
                end
            end
            default: state_d = S_IDLE0;
        endcase
        cnt_d = (state_d != state_q) ? '0 : cnt_q + CW'(1);
    end

    always_comb begin
        rack_out_o = 1'b1;
        rack_tri_o = 1'b0;
        rack_ce_o  = 1'b0;
        case (state_q)
            S_PRE:          rack_out_o = ~cnt_q[0];
            S_ADDR, S_DATA: rack_out_o = tx_q[TXW-1];
            S_PAR:          rack_out_o = ~par_q;
            S_TA0, S_POST, S_START, S_CAP, S_IDLE1: begin
                rack_tri_o = 1'b1;
                rack_ce_o  = 1'b1;
            end
            S_DONE:         rack_tri_o = 1'b1;
            S_FAIL:         rack_tri_o = mode_q;
            default: ;
        endcase
    end

    assign bus.txn_resp_o = resp_q;
    assign bus.txn_done_o = (state_q == S_DONE);
    assign bus.txn_err_o  = (state_q == S_FAIL) && !can_retry;
    assign bus.txn_perr_o = (state_q == S_FAIL) && !can_retry && perr_q;
    assign bus.mode_o     = mode_q;
    assign state_o        = state_q;
endmodule

// File: tb/tb_surf_rackctl_mphy.sv
// Bench for surf_rackctl_mphy: scripted SURF responses, per-cycle expected line/pulse trace.
module tb_surf_rackctl_mphy;
    localparam int AB = 24;
    localparam int DB = 32;
    localparam int TA = 128;
    localparam int TO = 128;
    localparam int EW = DB + 7;

    // clock / reset
    logic sysclk = 1'b0;
    logic rst = 1'b1;
    logic rack_in = 1'b1;
    logic rack_out, rack_tri, rack_ce;
    logic [3:0] dut_state;
    always #5 sysclk = ~sysclk;

    surf_rackctl_mphy_if #(.ADDR_BITS(AB), .DATA_BITS(DB)) bus ();

    surf_rackctl_mphy #(
        .ADDR_BITS(AB), .DATA_BITS(DB), .TURNAROUND_CLKS(TA), .TIMEOUT_CLKS(TO), .MAX_RETRY(1)
    ) dut (
        .sysclk_i   (sysclk),
        .rst_i      (rst),
        .bus        (bus),
        .rack_out_o (rack_out),
        .rack_tri_o (rack_tri),
        .rack_ce_o  (rack_ce),
        .rack_in_i  (rack_in),
        .state_o    (dut_state)
    );

    // expected trace: {resp, mode, perr, err, done, ce, tri, out} per cycle, plus SURF line script
    logic [EW-1:0] exp_q[$];
    logic          rx_q[$];
    logic          m_mode;
    logic [DB-1:0] m_resp;
    int            checks = 0;
    int            failures = 0;
    int            cyc = 0;
    string         scn = "init";
    logic [EW-1:0] cmp_exp, cmp_act, cmp_mask;

    function automatic logic par_of(input logic [DB-1:0] d);
        return ($countones(d) % 2) == 0;
    endfunction

    task automatic push(input logic o, input logic t, input logic c, input logic dn,
                        input logic er, input logic pe, input logic rx);
        exp_q.push_back({m_resp, m_mode, pe, er, dn, c, t, o});
        rx_q.push_back(rx);
    endtask

    task automatic push_drive(input logic b);
        push(b, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic push_listen(input logic rx);
        push(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, rx);
    endtask

    task automatic push_done();
        push(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic push_fail(input logic exhausted, input logic pe);
        push(1'b1, m_mode, 1'b0, 1'b0, exhausted, exhausted & pe, 1'b1);
    endtask

    task automatic push_ta1();
        repeat (TA) push_drive(1'b1);
    endtask

    task automatic push_idle(input int n);
        repeat (n) begin
            if (m_mode) push_listen(1'b1);
            else push_drive(1'b1);
        end
    endtask

    // outgoing frame: preamble, address, data for writes, parity, then the turnaround
    task automatic tx_frame(input logic [AB-1:0] a, input logic [DB-1:0] d);
        int ones;
        for (int i = 0; i < 5; i++) push_drive((i % 2) == 0);
        for (int i = AB - 1; i >= 0; i--) push_drive(a[i]);
        ones = $countones(a);
        if (!a[AB-1]) begin
            for (int i = DB - 1; i >= 0; i--) push_drive(d[i]);
            ones += $countones(d);
        end
        push_drive((ones % 2) == 0);
        repeat (TA) push_listen(1'b1);
    endtask

    // SURF reply: POST level, start bit after s idle clocks (s<0: none), optional data + parity
    task automatic rx_frame(input logic post_ok, input int s, input logic capture,
                            input logic [DB-1:0] d, input logic p);
        push_listen(post_ok);
        if (!post_ok) return;
        if (s < 0) begin
            repeat (TO) push_listen(1'b1);
            return;
        end
        repeat (s) push_listen(1'b1);
        push_listen(1'b0);
        if (capture) begin
            for (int i = DB - 1; i >= 0; i--) push_listen(d[i]);
            push_listen(p);
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    // driver: call at a negedge right after building the trace for the cycles that follow
    task automatic run(input string name, input logic strobe, input int stray_at,
                       input int rst_at, input int pin_idx, input logic pin_val);
        int n;
        scn = name;
        cyc = 0;
        n = rx_q.size();
        bus.txn_start_i = strobe;
        for (int k = 0; k < n; k++) begin
            @(negedge sysclk);
            if (k == pin_idx) chk({name, "_pin"}, 64'(rack_out), 64'(pin_val));
            bus.txn_start_i = (k == stray_at);
            rst = (k == rst_at);
            rack_in = rx_q[k];
        end
        @(negedge sysclk);
        bus.txn_start_i = 1'b0;
        rst = 1'b0;
        rack_in = 1'b1;
        rx_q.delete();
        chk({name, "_drain"}, 64'(exp_q.size()), 64'd0);
    endtask

    // scoreboard compare, every cycle with an expectation pending
    always @(posedge sysclk) begin
        #1;
        if (exp_q.size() > 0) begin
            cmp_exp = exp_q.pop_front();
            cmp_act = {bus.txn_resp_o, bus.mode_o, bus.txn_perr_o, bus.txn_err_o,
                       bus.txn_done_o, rack_ce, rack_tri, rack_out};
            cmp_mask = '1;
            if (cmp_exp[1]) cmp_mask[0] = 1'b0;
            checks++;
            if ((cmp_act & cmp_mask) !== (cmp_exp & cmp_mask)) begin
                failures++;
                $display("FAIL %s cycle=%0d got=%h want=%h", scn, cyc, cmp_act, cmp_exp);
            end
            cyc++;
        end
    end

    initial begin
        bus.mode_i = 1'b0;
        bus.txn_addr_i = '0;
        bus.txn_data_i = '0;
        bus.txn_start_i = 1'b0;
        m_mode = 1'b0;
        m_resp = '0;
        repeat (3) @(negedge sysclk);
        chk("rst_out", 64'(rack_out), 64'd1);
        chk("rst_tri", 64'(rack_tri), 64'd0);
        chk("rst_ce", 64'(rack_ce), 64'd0);
        chk("rst_mode", 64'(bus.mode_o), 64'd0);
        chk("rst_resp", 64'(bus.txn_resp_o), 64'd0);
        chk("rst_pulses", 64'({bus.txn_done_o, bus.txn_err_o, bus.txn_perr_o}), 64'd0);
        rst = 1'b0;

        // write; stray start during TA0 is ignored; parity bit hand-computed (31 ones -> 0)
        @(negedge sysclk);
        bus.txn_addr_i = 24'h012345;
        bus.txn_data_i = 32'hDEADBEEF;
        tx_frame(24'h012345, 32'hDEADBEEF);
        rx_frame(1'b1, 9, 1'b0, '0, 1'b0);
        push_done();
        push_ta1();
        push_idle(4);
        run("write", 1'b1, 100, -1, 61, 1'b0);

        // read; address parity hand-computed (2 ones -> 1)
        @(negedge sysclk);
        bus.txn_addr_i = 24'h800010;
        tx_frame(24'h800010, '0);
        rx_frame(1'b1, 3, 1'b1, 32'hCAFEF00D, 1'b1);
        m_resp = 32'hCAFEF00D;
        push_done();
        push_ta1();
        push_idle(4);
        run("read", 1'b1, -1, -1, 29, 1'b1);
        chk("read_resp", 64'(bus.txn_resp_o), 64'hCAFEF00D);

        // read with bad rx parity on both attempts
        @(negedge sysclk);
        bus.txn_addr_i = 24'h800020;
        tx_frame(24'h800020, '0);
        rx_frame(1'b1, 2, 1'b1, 32'h12345678, ~par_of(32'h12345678));
        push_fail(1'b0, 1'b1);
        push_ta1();
        tx_frame(24'h800020, '0);
        rx_frame(1'b1, 5, 1'b1, 32'h12345678, ~par_of(32'h12345678));
        push_fail(1'b1, 1'b1);
        push_ta1();
        push_idle(4);
        run("rd_badpar", 1'b1, -1, -1, -1, 1'b0);
        chk("badpar_resp", 64'(bus.txn_resp_o), 64'hCAFEF00D);

        // write with no start bit at all
        @(negedge sysclk);
        bus.txn_addr_i = 24'h000055;
        bus.txn_data_i = 32'h0F0F0F0F;
        tx_frame(24'h000055, 32'h0F0F0F0F);
        rx_frame(1'b1, -1, 1'b0, '0, 1'b0);
        push_fail(1'b0, 1'b0);
        push_ta1();
        tx_frame(24'h000055, 32'h0F0F0F0F);
        rx_frame(1'b1, -1, 1'b0, '0, 1'b0);
        push_fail(1'b1, 1'b0);
        push_ta1();
        push_idle(4);
        run("wr_timeout", 1'b1, -1, -1, -1, 1'b0);

        // read: line low in POST first, retry succeeds with immediate start bit
        @(negedge sysclk);
        bus.txn_addr_i = 24'h800001;
        tx_frame(24'h800001, '0);
        rx_frame(1'b0, 0, 1'b1, '0, 1'b0);
        push_fail(1'b0, 1'b0);
        push_ta1();
        tx_frame(24'h800001, '0);
        rx_frame(1'b1, 0, 1'b1, 32'h00000001, 1'b0);
        m_resp = 32'h00000001;
        push_done();
        push_ta1();
        push_idle(4);
        run("rd_postlow", 1'b1, -1, -1, -1, 1'b0);

        // mode 0->1 with simultaneous start: switch first, then the parked read via POST
        @(negedge sysclk);
        bus.mode_i = 1'b1;
        bus.txn_addr_i = 24'h000000;
        repeat (TA) push_listen(1'b1);
        m_mode = 1'b1;
        push_done();
        push_listen(1'b1);
        rx_frame(1'b1, 4, 1'b1, 32'hA5A50FF0, 1'b1);
        m_resp = 32'hA5A50FF0;
        push_done();
        push_idle(4);
        run("sw01_read", 1'b1, -1, -1, -1, 1'b0);
        chk("sw01_mode", 64'(bus.mode_o), 64'd1);
        chk("sw01_resp", 64'(bus.txn_resp_o), 64'hA5A50FF0);

        // mode 1 read: bad parity, direct re-issue to POST, then good
        @(negedge sysclk);
        rx_frame(1'b1, 1, 1'b1, 32'h000000FF, 1'b0);
        push_fail(1'b0, 1'b1);
        rx_frame(1'b1, 2, 1'b1, 32'h000000FF, 1'b1);
        m_resp = 32'h000000FF;
        push_done();
        push_idle(4);
        run("m1_retry", 1'b1, -1, -1, -1, 1'b0);

        // mode 1->0 without start
        @(negedge sysclk);
        bus.mode_i = 1'b0;
        m_mode = 1'b0;
        push_done();
        push_ta1();
        push_idle(4);
        run("sw10", 1'b0, -1, -1, -1, 1'b0);
        chk("sw10_mode", 64'(bus.mode_o), 64'd0);

        // reset during the DATA phase of a write
        @(negedge sysclk);
        bus.txn_addr_i = 24'h00ABCD;
        bus.txn_data_i = 32'h13579BDF;
        tx_frame(24'h00ABCD, 32'h13579BDF);
        while (exp_q.size() > 41) begin
            void'(exp_q.pop_back());
            void'(rx_q.pop_back());
        end
        m_resp = '0;
        push_idle(8);
        run("rst_data", 1'b1, -1, 40, -1, 1'b0);
        chk("rst_data_resp", 64'(bus.txn_resp_o), 64'd0);

        repeat (2) @(negedge sysclk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
